// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 self-test: op encodings, vector field layout,
// sequencer states and the response bundle compared in CHECK.
package alu4_pkg;

  localparam int VEC_W = 13;
  localparam int ALU_W = 4;
  localparam logic [VEC_W-1:0] FAIL_NONE = 13'h1FFF;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_ADD = 2'b11;

  // Vector layout, LSB first: a, b, carry-in, b_zero, b_inv, op.
  localparam int A_LSB  = 0;
  localparam int B_LSB  = 4;
  localparam int Y_BIT  = 8;
  localparam int BZ_BIT = 9;
  localparam int BI_BIT = 10;
  localparam int OP_LSB = 11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CHECK,
    ST_DONE
  } st_e;

  typedef struct packed {
    logic [ALU_W-1:0] s;
    logic             c;
    logic             zero;
    logic             ovf;
  } alu_rsp_t;

endpackage

// File: rtl/alu4_model.sv
// Combinational golden reference for the 4-bit ALU: logic ops on the
// conditioned b operand, or add with carry-in and signed overflow.
module alu4_model
  import alu4_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int OP_WIDTH = 2
) (
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  input  logic                y,
  input  logic                b_zero,
  input  logic                b_inv,
  input  logic [OP_WIDTH-1:0] op,
  output logic [WIDTH-1:0]    s,
  output logic                c,
  output logic                zero,
  output logic                overflow
);

  logic [WIDTH-1:0] beff;
  logic [WIDTH:0]   sum;

  always_comb begin
    beff     = (b_zero ? '0 : b) ^ {WIDTH{b_inv}};
    sum      = {1'b0, a} + {1'b0, beff} + {{WIDTH{1'b0}}, y};
    s        = '0;
    c        = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND:  s = a & beff;
      OP_OR:   s = a | beff;
      OP_XOR:  s = a ^ beff;
      OP_ADD: begin
        s        = sum[WIDTH-1:0];
        c        = sum[WIDTH];
        // Same-sign operands producing an opposite-sign result.
        overflow = (a[WIDTH-1] == beff[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
      end
      default: s = '0;
    endcase
    zero = (s == '0);
  end

endmodule

// File: rtl/alu4_selftest.sv
// Exhaustive built-in self-test for the alu4: walks all 8192 operand/control
// vectors, checks each ALU response against alu4_model, and latches a verdict.
module alu4_selftest
  import alu4_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int OP_WIDTH = 2,
  parameter int SETTLE   = 1,
  parameter int ERR_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                start,
  output logic [WIDTH-1:0]    a_o,
  output logic [WIDTH-1:0]    b_o,
  output logic                y_o,
  output logic                b_zero_o,
  output logic                b_inv_o,
  output logic [OP_WIDTH-1:0] op_o,
  input  logic [WIDTH-1:0]    s_i,
  input  logic                c_i,
  input  logic                zero_i,
  input  logic                overflow_i,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ERR_W-1:0]    err_count,
  output logic [VEC_W-1:0]    fail_vec
);

  localparam int CNT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  st_e              state;
  logic [VEC_W-1:0] vec;
  logic [CNT_W-1:0] cnt;
  alu_rsp_t         exp_rsp;
  alu_rsp_t         got_rsp;
  logic             mismatch;

  // The ALU sees the vector register straight, so the drive side is glitch-free.
  assign a_o      = vec[A_LSB +: WIDTH];
  assign b_o      = vec[B_LSB +: WIDTH];
  assign y_o      = vec[Y_BIT];
  assign b_zero_o = vec[BZ_BIT];
  assign b_inv_o  = vec[BI_BIT];
  assign op_o     = vec[OP_LSB +: OP_WIDTH];

  alu4_model #(
    .WIDTH    (WIDTH),
    .OP_WIDTH (OP_WIDTH)
  ) u_model (
    .a        (a_o),
    .b        (b_o),
    .y        (y_o),
    .b_zero   (b_zero_o),
    .b_inv    (b_inv_o),
    .op       (op_o),
    .s        (exp_rsp.s),
    .c        (exp_rsp.c),
    .zero     (exp_rsp.zero),
    .overflow (exp_rsp.ovf)
  );

  assign got_rsp  = '{s: s_i, c: c_i, zero: zero_i, ovf: overflow_i};
  assign mismatch = (got_rsp != exp_rsp);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vec       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= FAIL_NONE;
    end else if (ena) begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_SETTLE;
            vec       <= '0;
            cnt       <= CNT_W'(SETTLE);
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= FAIL_NONE;
          end
        end
        ST_SETTLE: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= ST_CHECK;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != '1) err_count <= err_count + ERR_W'(1);
            if (fail_vec == FAIL_NONE) fail_vec <= vec;
          end
          if (vec == FAIL_NONE) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            // Fold in this cycle's result; err_count updates on the same edge.
            pass  <= (err_count == '0) && !mismatch;
          end else begin
            state <= ST_SETTLE;
            vec   <= vec + VEC_W'(1);
            cnt   <= CNT_W'(SETTLE);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
